// File: rtl/vending_fsm_core.sv
// Vending-machine controller: accumulates coin credit, dispenses one product on select and
// pays change (or refunds the whole credit on cancel) one coin per cycle, largest coin first.
// State and credit live in internal registers; every output is a flop.
// Parameter constraints: PRICE and MAX_CREDIT are multiples of 5, 0 < PRICE <= MAX_CREDIT,
// and 2**CREDIT_W > MAX_CREDIT.
module vending_fsm_core #(
    parameter int unsigned PRICE      = 35,
    parameter int unsigned MAX_CREDIT = 100,
    parameter int unsigned CREDIT_W   = 7
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [2:0]          coin,
    input  logic                sel,
    input  logic                cancel,
    output logic                dispense,
    output logic                ret_25,
    output logic                ret_10,
    output logic                ret_5,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    // Binary encoding is the NS/CS vector shared with the state flops.
    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StCollect  = 2'b01,
        StDispense = 2'b10,
        StChange   = 2'b11
    } state_e;

    // Coin arithmetic uses one extra bit so credit + coin can never wrap.
    localparam int unsigned SumW = CREDIT_W + 1;

    localparam logic [SumW-1:0]     MaxSum  = SumW'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PriceC  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] Val25   = CREDIT_W'(25);
    localparam logic [CREDIT_W-1:0] Val10   = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] Val5    = CREDIT_W'(5);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_d;

    logic                coin_valid;
    logic                coin_any;
    logic [SumW-1:0]     coin_value;
    logic [SumW-1:0]     coin_sum;
    logic                coin_fits;
    logic [CREDIT_W-1:0] ret_amt;

    logic                dispense_d, ret_25_d, ret_10_d, ret_5_d, busy_d;

    // Decode the coin pulse; anything but a single hot bit is not a coin.
    always_comb begin
        coin_valid = 1'b0;
        coin_value = '0;
        unique case (coin)
            3'b001: begin coin_valid = 1'b1; coin_value = SumW'(5);  end
            3'b010: begin coin_valid = 1'b1; coin_value = SumW'(10); end
            3'b100: begin coin_valid = 1'b1; coin_value = SumW'(25); end
            default: ;
        endcase
        coin_any  = (coin != 3'b000);
        coin_sum  = {1'b0, credit_q} + coin_value;
        coin_fits = (coin_sum <= MaxSum);
    end

    // Coin paid out this CHANGE cycle: largest denomination not exceeding the credit.
    always_comb begin
        if (credit_q >= Val25) begin
            ret_amt = Val25;
        end else if (credit_q >= Val10) begin
            ret_amt = Val10;
        end else begin
            ret_amt = Val5;
        end
    end

    // Next state, next credit and the coin-reject decision.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (coin_valid && coin_fits) begin
                    credit_d = coin_sum[CREDIT_W-1:0];
                    state_d  = StCollect;
                end else if (coin_any) begin
                    reject_d = 1'b1;
                end
            end
            StCollect: begin
                if (cancel) begin
                    state_d  = StChange;
                    reject_d = coin_any;
                end else if (sel && (credit_q >= PriceC)) begin
                    state_d  = StDispense;
                    reject_d = coin_any;
                end else if (coin_valid && coin_fits) begin
                    credit_d = coin_sum[CREDIT_W-1:0];
                end else if (coin_any) begin
                    reject_d = 1'b1;
                end
            end
            StDispense: begin
                credit_d = credit_q - PriceC;
                state_d  = (credit_d != '0) ? StChange : StIdle;
                reject_d = coin_any;
            end
            StChange: begin
                credit_d = credit_q - ret_amt;
                state_d  = (credit_d != '0) ? StChange : StIdle;
                reject_d = coin_any;
            end
            default: begin
                state_d  = StIdle;
                credit_d = '0;
            end
        endcase
    end

    // Output pulses for the coming cycle, derived from the next state and credit.
    always_comb begin
        dispense_d = (state_d == StDispense);
        busy_d     = (state_d == StDispense) || (state_d == StChange);
        ret_25_d   = 1'b0;
        ret_10_d   = 1'b0;
        ret_5_d    = 1'b0;
        if (state_d == StChange) begin
            if (credit_d >= Val25) begin
                ret_25_d = 1'b1;
            end else if (credit_d >= Val10) begin
                ret_10_d = 1'b1;
            end else begin
                ret_5_d = 1'b1;
            end
        end
    end

    // State, credit and output registers; synchronous reset drops any pending change.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            credit_q    <= '0;
            dispense    <= 1'b0;
            ret_25      <= 1'b0;
            ret_10      <= 1'b0;
            ret_5       <= 1'b0;
            coin_reject <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            dispense    <= dispense_d;
            ret_25      <= ret_25_d;
            ret_10      <= ret_10_d;
            ret_5       <= ret_5_d;
            coin_reject <= reject_d;
            busy        <= busy_d;
        end
    end

    assign credit = credit_q;

endmodule

// File: tb/tb_vending_fsm_core.sv
// Self-checking bench for vending_fsm_core: a transaction-level model (credit plus a queue of
// pending payout events) is compared against the DUT every cycle, alongside hand-computed checks.
module tb_vending_fsm_core;

    localparam int PRICE    = 35;
    localparam int MAX_CR   = 100;
    localparam int CREDIT_W = 7;

    localparam logic [2:0] C0  = 3'b000;
    localparam logic [2:0] C5  = 3'b001;
    localparam logic [2:0] C10 = 3'b010;
    localparam logic [2:0] C25 = 3'b100;

    logic                CLK = 1'b0;
    logic                RST;
    logic [2:0]          coin;
    logic                sel;
    logic                cancel;
    logic                dispense, ret_25, ret_10, ret_5, coin_reject, busy;
    logic [CREDIT_W-1:0] credit;

    int n_checks = 0;
    int n_fail   = 0;

    vending_fsm_core #(
        .PRICE      (PRICE),
        .MAX_CREDIT (MAX_CR),
        .CREDIT_W   (CREDIT_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .coin        (coin),
        .sel         (sel),
        .cancel      (cancel),
        .dispense    (dispense),
        .ret_25      (ret_25),
        .ret_10      (ret_10),
        .ret_5       (ret_5),
        .coin_reject (coin_reject),
        .credit      (credit),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    // Model: credit in cents and a queue of payout events (0 = dispense, else coin value).
    int m_cr  = 0;
    int m_q[$];
    bit m_rej = 1'b0;
    bit m_en  = 1'b0;

    task automatic add_change(input int amt);
        int a;
        a = amt;
        while (a > 0) begin
            if (a >= 25)      begin m_q.push_back(25); a -= 25; end
            else if (a >= 10) begin m_q.push_back(10); a -= 10; end
            else              begin m_q.push_back(5);  a -= 5;  end
        end
    endtask

    always @(posedge CLK) begin
        int val;
        if (RST) begin
            m_cr  = 0;
            m_q.delete();
            m_rej = 1'b0;
            m_en  = 1'b1;
        end else begin
            m_rej = 1'b0;
            val = (coin == C5) ? 5 : (coin == C10) ? 10 : (coin == C25) ? 25 : 0;
            if (m_q.size() > 0) begin
                // The event shown last cycle completes; inputs were ignored while busy.
                m_cr -= (m_q[0] == 0) ? PRICE : m_q[0];
                void'(m_q.pop_front());
                m_rej = (coin != C0);
            end else if (m_cr == 0) begin
                if (val != 0 && val <= MAX_CR) m_cr = val;
                else if (coin != C0) m_rej = 1'b1;
            end else if (cancel) begin
                add_change(m_cr);
                m_rej = (coin != C0);
            end else if (sel && m_cr >= PRICE) begin
                m_q.push_back(0);
                add_change(m_cr - PRICE);
                m_rej = (coin != C0);
            end else if (val != 0 && m_cr + val <= MAX_CR) begin
                m_cr += val;
            end else if (coin != C0) begin
                m_rej = 1'b1;
            end
        end
    end

    function automatic logic [12:0] ev(input bit d, input bit r25, input bit r10, input bit r5,
                                       input bit rej, input bit bsy, input int cr);
        return {d, r25, r10, r5, rej, bsy, 7'(cr)};
    endfunction

    function automatic logic [12:0] outs();
        return {dispense, ret_25, ret_10, ret_5, coin_reject, busy, credit};
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        int head;
        logic [12:0] exp_v;
        if (m_en) begin
            head  = (m_q.size() > 0) ? m_q[0] : -1;
            exp_v = ev(head == 0, head == 25, head == 10, head == 5, m_rej, m_q.size() > 0, m_cr);
            n_checks++;
            if (outs() !== exp_v) begin
                n_fail++;
                $display("FAIL model_compare t=%0t got d/r25/r10/r5/rej/busy/credit=%b_%0d expected %b_%0d",
                         $time, outs()[12:7], outs()[6:0], exp_v[12:7], exp_v[6:0]);
            end
        end
    end

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s got d/r25/r10/r5/rej/busy/credit=%b_%0d expected %b_%0d",
                     name, act[12:7], act[6:0], exp_v[12:7], exp_v[6:0]);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, return just after the sampling edge.
    task automatic cycle(input logic [2:0] c, input logic s, input logic k, input logic r);
        @(negedge CLK);
        coin   = c;
        sel    = s;
        cancel = k;
        RST    = r;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        cycle(C0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        RST    = 1'b1;
        coin   = C0;
        sel    = 1'b0;
        cancel = 1'b0;

        // Reset with random inputs.
        cycle(3'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        check("reset_first_edge", outs(), ev(0, 0, 0, 0, 0, 0, 0));
        cycle(3'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        idle();
        check("after_reset_idle", outs(), ev(0, 0, 0, 0, 0, 0, 0));

        // sel/cancel ignored in IDLE; multi-hot coin rejected.
        cycle(C0, 1'b1, 1'b1, 1'b0);
        check("idle_sel_cancel_ignored", outs(), ev(0, 0, 0, 0, 0, 0, 0));
        cycle(3'b111, 1'b0, 1'b0, 1'b0);
        check("idle_multihot_reject", outs(), ev(0, 0, 0, 0, 1, 0, 0));

        // Exact payment.
        cycle(C25, 1'b0, 1'b0, 1'b0);
        check("exact_credit_25", outs(), ev(0, 0, 0, 0, 0, 0, 25));
        cycle(C10, 1'b0, 1'b0, 1'b0);
        check("exact_credit_35", outs(), ev(0, 0, 0, 0, 0, 0, 35));
        cycle(C0, 1'b1, 1'b0, 1'b0);
        check("exact_dispense", outs(), ev(1, 0, 0, 0, 0, 1, 35));
        idle();
        check("exact_back_idle", outs(), ev(0, 0, 0, 0, 0, 0, 0));

        // Overpayment: 50c, change 15c as 10c then 5c.
        cycle(C25, 1'b0, 1'b0, 1'b0);
        cycle(C25, 1'b0, 1'b0, 1'b0);
        cycle(C0, 1'b1, 1'b0, 1'b0);
        check("over_dispense", outs(), ev(1, 0, 0, 0, 0, 1, 50));
        idle();
        check("over_ret10", outs(), ev(0, 0, 1, 0, 0, 1, 15));
        idle();
        check("over_ret5", outs(), ev(0, 0, 0, 1, 0, 1, 5));
        idle();
        check("over_back_idle", outs(), ev(0, 0, 0, 0, 0, 0, 0));

        // Cancel refunds 40c as 25, 10, 5.
        cycle(C25, 1'b0, 1'b0, 1'b0);
        cycle(C10, 1'b0, 1'b0, 1'b0);
        cycle(C5, 1'b0, 1'b0, 1'b0);
        cycle(C0, 1'b0, 1'b1, 1'b0);
        check("cancel_ret25", outs(), ev(0, 1, 0, 0, 0, 1, 40));
        idle();
        check("cancel_ret10", outs(), ev(0, 0, 1, 0, 0, 1, 15));
        idle();
        check("cancel_ret5", outs(), ev(0, 0, 0, 1, 0, 1, 5));
        idle();
        check("cancel_back_idle", outs(), ev(0, 0, 0, 0, 0, 0, 0));

        // Overflow limit, multi-hot in COLLECT, coin with cancel, coin while busy.
        cycle(C25, 1'b0, 1'b0, 1'b0);
        cycle(C25, 1'b0, 1'b0, 1'b0);
        cycle(C25, 1'b0, 1'b0, 1'b0);
        cycle(C10, 1'b0, 1'b0, 1'b0);
        cycle(C5, 1'b0, 1'b0, 1'b0);
        check("credit_90", outs(), ev(0, 0, 0, 0, 0, 0, 90));
        cycle(C25, 1'b0, 1'b0, 1'b0);
        check("overflow_reject", outs(), ev(0, 0, 0, 0, 1, 0, 90));
        cycle(3'b011, 1'b0, 1'b0, 1'b0);
        check("multihot_reject", outs(), ev(0, 0, 0, 0, 1, 0, 90));
        cycle(C10, 1'b0, 1'b0, 1'b0);
        check("fill_to_max", outs(), ev(0, 0, 0, 0, 0, 0, 100));
        cycle(C5, 1'b0, 1'b1, 1'b0);
        check("cancel_with_coin", outs(), ev(0, 1, 0, 0, 1, 1, 100));
        cycle(C10, 1'b0, 1'b0, 1'b0);
        check("coin_while_busy", outs(), ev(0, 1, 0, 0, 1, 1, 75));
        idle();
        idle();
        idle();
        check("max_refund_done", outs(), ev(0, 0, 0, 0, 0, 0, 0));

        // sel below price ignored; sel plus coin at 40c.
        cycle(C25, 1'b0, 1'b0, 1'b0);
        cycle(C5, 1'b0, 1'b0, 1'b0);
        cycle(C0, 1'b1, 1'b0, 1'b0);
        check("sel_below_price", outs(), ev(0, 0, 0, 0, 0, 0, 30));
        cycle(C10, 1'b0, 1'b0, 1'b0);
        cycle(C10, 1'b1, 1'b0, 1'b0);
        check("sel_with_coin", outs(), ev(1, 0, 0, 0, 1, 1, 40));
        idle();
        check("sel_with_coin_change", outs(), ev(0, 0, 0, 1, 0, 1, 5));
        idle();

        // Reset during the second refund pulse of a 40c cancel.
        cycle(C25, 1'b0, 1'b0, 1'b0);
        cycle(C10, 1'b0, 1'b0, 1'b0);
        cycle(C5, 1'b0, 1'b0, 1'b0);
        cycle(C0, 1'b0, 1'b1, 1'b0);
        idle();
        check("midop_second_pulse", outs(), ev(0, 0, 1, 0, 0, 1, 15));
        cycle(C0, 1'b0, 1'b0, 1'b1);
        check("midop_reset", outs(), ev(0, 0, 0, 0, 0, 0, 0));
        idle();
        check("midop_no_more_ret", outs(), ev(0, 0, 0, 0, 0, 0, 0));
        cycle(C5, 1'b0, 1'b0, 1'b0);
        check("post_reset_coin", outs(), ev(0, 0, 0, 0, 0, 0, 5));
        cycle(C0, 1'b0, 1'b1, 1'b0);
        check("post_reset_refund", outs(), ev(0, 0, 0, 1, 0, 1, 5));
        idle();
        idle();

        @(negedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
